// File: rtl/btn_load_ctrl_pkg.sv
// Shared definitions for the button/switch load front-end: FSM state codes,
// strobe kind encoding and the default debounce length.
package btn_load_ctrl_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W           = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        FIRE     = 3'd2,
        REL_WAIT = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    typedef enum logic {
        KIND_LOAD = 1'b0,
        KIND_CLR  = 1'b1
    } kind_t;

endpackage

// File: rtl/btn_load_ctrl_sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous board inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; only the second stage is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_load_ctrl.sv
// Turns raw buttons and switches into debounced one-cycle load/clear strobes
// plus held data for the downstream 4-bit enable/reset register.
module btn_load_ctrl
    import btn_load_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_load,
    input  logic       btn_clr,
    input  logic [3:0] sw,
    output logic [3:0] data_out,
    output logic       load_en,
    output logic       clr_en,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       btn_s;
    logic [3:0]       sw_s;
    logic             load_s;
    logic             clr_s;
    logic             sel_s;

    state_t           state;
    state_t           state_nxt;
    kind_t            kind;
    kind_t            kind_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       data_nxt;
    logic             load_nxt;
    logic             clr_nxt;

    sync_2ff #(.WIDTH(2)) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({btn_clr, btn_load}),
        .q     (btn_s)
    );

    sync_2ff #(.WIDTH(4)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_s)
    );

    assign load_s = btn_s[0];
    assign clr_s  = btn_s[1];
    assign sel_s  = (kind == KIND_CLR) ? clr_s : load_s;

    // Strobes are registered so the downstream enable/reset pins see glitch-free pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            kind     <= KIND_LOAD;
            cnt      <= '0;
            data_out <= '0;
            load_en  <= 1'b0;
            clr_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            kind     <= kind_nxt;
            cnt      <= cnt_nxt;
            data_out <= data_nxt;
            load_en  <= load_nxt;
            clr_en   <= clr_nxt;
        end
    end

    // Press must stay high DEBOUNCE_CYCLES more cycles; release must stay low as long.
    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        cnt_nxt   = cnt;
        data_nxt  = data_out;
        unique case (state)
            IDLE: begin
                if (clr_s || load_s) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                    kind_nxt  = clr_s ? KIND_CLR : KIND_LOAD;
                end
            end
            PRESS_DB: begin
                if (!sel_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = FIRE;
                    if (kind == KIND_LOAD) begin
                        data_nxt = sw_s;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FIRE: begin
                state_nxt = REL_WAIT;
            end
            REL_WAIT: begin
                if (!clr_s && !load_s) begin
                    state_nxt = REL_DB;
                    cnt_nxt   = '0;
                end
            end
            REL_DB: begin
                if (clr_s || load_s) begin
                    state_nxt = REL_WAIT;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        load_nxt = (state == FIRE) && (kind == KIND_LOAD);
        clr_nxt  = (state == FIRE) && (kind == KIND_CLR);
    end

endmodule
